// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encoding and FSM states.
package lsu_pkg;

  // Access size as carried on lsu_size; 2'b11 is reserved and treated as misaligned.
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, load
// extraction/extension and misalignment detection for one access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  // Decode size/offset into lane controls and the extended load value.
  always_comb begin
    be_o       = '0;
    wdata_o    = wdata_i;
    rdata_o    = '0;
    misalign_o = 1'b0;
    shifted    = rdata_i >> {offset_i, 3'b000};
    case (lsu_size_e'(size_i))
      BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        be_o       = 4'b0011 << offset_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        misalign_o = offset_i[0];
      end
      WORD: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = shifted;
        misalign_o = |offset_i;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: bridges single core load/store requests to a word-wide
// data RAM with a req/gnt/rvalid handshake, one transaction outstanding.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lsu_req,
  output logic                  lsu_ready,
  input  logic                  lsu_we,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [31:0]           lsu_wdata,
  output logic                  lsu_rvalid,
  output logic [31:0]           lsu_rdata,
  output logic                  lsu_err,
  output logic                  ram_req,
  input  logic                  ram_gnt,
  input  logic                  ram_rvalid,
  output logic                  ram_we,
  output logic [3:0]            ram_be,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_err
);

  lsu_state_e            state_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  lsu_rvalid_q;
  logic                  lsu_err_q;
  logic [31:0]           lsu_rdata_q;
  logic                  ram_req_q;
  logic                  ram_we_q;
  logic [3:0]            ram_be_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [31:0]           ram_wdata_q;

  logic                  idle;
  logic [1:0]            al_off;
  logic [1:0]            al_size;
  logic                  al_uns;
  logic [3:0]            al_be;
  logic [31:0]           al_wdata;
  logic [31:0]           al_rdata;
  logic                  al_mis;

  assign idle = (state_q == S_IDLE);

  // One aligner serves both phases: in IDLE it decodes the incoming request,
  // otherwise it extracts load data using the captured offset/size/sign.
  always_comb begin
    al_off  = idle ? lsu_addr[1:0] : off_q;
    al_size = idle ? lsu_size      : size_q;
    al_uns  = idle ? lsu_unsigned  : uns_q;
  end

  lsu_align u_align (
    .offset_i   (al_off),
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .wdata_i    (lsu_wdata),
    .rdata_i    (ram_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_mis)
  );

  // Transaction FSM with registered RAM-side and response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_be_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (lsu_req) begin
            off_q  <= lsu_addr[1:0];
            size_q <= lsu_size;
            uns_q  <= lsu_unsigned;
            if (al_mis) begin
              lsu_rvalid_q <= 1'b1;
              lsu_err_q    <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              ram_req_q   <= 1'b1;
              ram_we_q    <= lsu_we;
              ram_be_q    <= al_be;
              ram_addr_q  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
              ram_wdata_q <= al_wdata;
            end
          end
        end
        S_REQ: begin
          if (ram_gnt) begin
            ram_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ram_rvalid) begin
            lsu_rvalid_q <= 1'b1;
            lsu_err_q    <= ram_err;
            lsu_rdata_q  <= (ram_we_q || ram_err) ? '0 : al_rdata;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lsu_ready  = idle;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_err    = lsu_err_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign ram_req    = ram_req_q;
  assign ram_we     = ram_we_q;
  assign ram_be     = ram_be_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req;
  logic        lsu_ready;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        ram_req;
  logic        ram_gnt;
  logic        ram_rvalid;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .lsu_req      (lsu_req),
    .lsu_ready    (lsu_ready),
    .lsu_we       (lsu_we),
    .lsu_size     (lsu_size),
    .lsu_unsigned (lsu_unsigned),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_rdata    (lsu_rdata),
    .lsu_err      (lsu_err),
    .ram_req      (ram_req),
    .ram_gnt      (ram_gnt),
    .ram_rvalid   (ram_rvalid),
    .ram_we       (ram_we),
    .ram_be       (ram_be),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_err      (ram_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic mis_of(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return off[0];
    if (size == 2'b10) return (off != 2'b00);
    return 1'b1;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'b00) return 4'(1 << off);
    if (size == 2'b01) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_of(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    if (size == 2'b00)      r = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    else if (size == 2'b01) r = {wd[15:0], wd[15:0]};
    else                    r = wd;
    return r;
  endfunction

  // One complete request: drive, track RAM side, then pop and compare the response.
  task automatic do_txn(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_delay, input logic [31:0] rdata, input logic err,
                        input logic [31:0] exp_rdata);
    int    lat;
    logic  mis;
    resp_t r;
    mis = mis_of(size, addr[1:0]);
    chk({tag, ":ready"}, 32'(lsu_ready), 32'd1);
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    r.rdata = mis ? 32'd0 : exp_rdata;
    r.err   = mis ? 1'b1 : err;
    exp_q.push_back(r);
    @(negedge clk); lat = 1;
    lsu_req = 1'b0;
    if (!mis) begin
      for (int i = 0; i <= gnt_delay; i++) begin
        chk({tag, ":ram_req"},   32'(ram_req), 32'd1);
        chk({tag, ":ram_addr"},  ram_addr, {addr[31:2], 2'b00});
        chk({tag, ":ram_be"},    32'(ram_be), 32'(be_of(size, addr[1:0])));
        chk({tag, ":ram_wdata"}, ram_wdata, wd_of(size, wdata));
        chk({tag, ":ram_we"},    32'(ram_we), 32'(we));
        chk({tag, ":busy"},      32'(lsu_ready), 32'd0);
        if (i == gnt_delay) ram_gnt = 1'b1;
        @(negedge clk); lat++;
      end
      ram_gnt = 1'b0;
      chk({tag, ":req_drop"}, 32'(ram_req), 32'd0);
      chk({tag, ":wait_busy"}, 32'(lsu_ready), 32'd0);
      ram_rvalid = 1'b1; ram_rdata = rdata; ram_err = err;
      @(negedge clk); lat++;
      ram_rvalid = 1'b0; ram_err = 1'b0; ram_rdata = 32'h5A5A_5A5A;
    end else begin
      chk({tag, ":no_ram_req"}, 32'(ram_req), 32'd0);
    end
    for (int i = 0; i < 8 && !lsu_rvalid; i++) begin
      @(negedge clk); lat++;
    end
    chk({tag, ":rvalid"}, 32'(lsu_rvalid), 32'd1);
    if (lsu_rvalid && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk({tag, ":rdata"}, lsu_rdata, r.rdata);
      chk({tag, ":err"}, 32'(lsu_err), 32'(r.err));
    end
    chk({tag, ":latency"}, 32'(lat), mis ? 32'd1 : 32'(3 + gnt_delay));
    @(negedge clk);
    chk({tag, ":pulse"}, 32'(lsu_rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'b10; lsu_unsigned = 1'b0;
    lsu_addr = 32'h0000_0100; lsu_wdata = 32'hFFFF_FFFF;
    ram_gnt = 1'b1; ram_rvalid = 1'b1; ram_rdata = 32'hFFFF_FFFF; ram_err = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst:rvalid", 32'(lsu_rvalid), 32'd0);
    chk("rst:err",    32'(lsu_err), 32'd0);
    chk("rst:rdata",  lsu_rdata, 32'd0);
    chk("rst:ram_req", 32'(ram_req), 32'd0);
    chk("rst:ram_we", 32'(ram_we), 32'd0);
    chk("rst:ram_be", 32'(ram_be), 32'd0);
    chk("rst:ram_addr", ram_addr, 32'd0);
    chk("rst:ram_wdata", ram_wdata, 32'd0);
    lsu_req = 1'b0; ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_err = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst:ready_after", 32'(lsu_ready), 32'd1);

    do_txn("st_b103", 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 0, 32'h0, 1'b0, 32'h0);
    chk("st_b103:be_const", 32'(ram_be), 32'h8);
    chk("st_b103:wd_const", ram_wdata, 32'hA5A5_A5A5);
    chk("st_b103:addr_const", ram_addr, 32'h0000_0100);
    do_txn("ld_h202s", 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 0, 32'h8001_1234, 1'b0, 32'hFFFF_8001);
    do_txn("ld_h202u", 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 1, 32'h8001_1234, 1'b0, 32'h0000_8001);
    do_txn("ld_b401s", 1'b0, 2'b00, 1'b0, 32'h0000_0401, 32'h0, 0, 32'h1234_80FF, 1'b0, 32'hFFFF_FF80);
    do_txn("ld_b403u", 1'b0, 2'b00, 1'b1, 32'h0000_0403, 32'h0, 0, 32'hAB00_0000, 1'b0, 32'h0000_00AB);
    do_txn("ld_h200s", 1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 0, 32'h8001_1234, 1'b0, 32'h0000_1234);
    do_txn("ld_w500", 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    do_txn("st_h602", 1'b1, 2'b01, 1'b0, 32'h0000_0602, 32'h1234_BEEF, 2, 32'hFFFF_FFFF, 1'b0, 32'h0);
    do_txn("ld_w301", 1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'h0, 0, 32'h0, 1'b0, 32'h0);
    do_txn("ld_h201", 1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0, 0, 32'h0, 1'b0, 32'h0);
    do_txn("st_rsv", 1'b1, 2'b11, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF, 0, 32'h0, 1'b0, 32'h0);
    do_txn("st_w_gnt4", 1'b1, 2'b10, 1'b0, 32'h0000_0A04, 32'hCAFE_F00D, 4, 32'h0, 1'b0, 32'h0);
    do_txn("ld_err", 1'b0, 2'b10, 1'b0, 32'h0000_0B00, 32'h0, 0, 32'hFFFF_FFFF, 1'b1, 32'h0);

    ram_rvalid = 1'b1; ram_err = 1'b1; ram_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("stray:rvalid1", 32'(lsu_rvalid), 32'd0);
    @(negedge clk);
    chk("stray:rvalid2", 32'(lsu_rvalid), 32'd0);
    ram_rvalid = 1'b0; ram_err = 1'b0;
    @(negedge clk);
    chk("stray:ready", 32'(lsu_ready), 32'd1);

    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'b10; lsu_unsigned = 1'b0; lsu_addr = 32'h0000_0700;
    @(negedge clk);
    lsu_req = 1'b0; ram_gnt = 1'b1;
    @(negedge clk);
    ram_gnt = 1'b0;
    chk("rstwait:in_wait", 32'(ram_req), 32'd0);
    chk("rstwait:busy", 32'(lsu_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstwait:rvalid_rst", 32'(lsu_rvalid), 32'd0);
    chk("rstwait:addr_rst", ram_addr, 32'd0);
    reset = 1'b1; ram_rvalid = 1'b1; ram_rdata = 32'h7777_7777;
    @(negedge clk);
    ram_rvalid = 1'b0;
    chk("rstwait:ready_release", 32'(lsu_ready), 32'd1);
    chk("rstwait:late_rvalid", 32'(lsu_rvalid), 32'd0);
    @(negedge clk);
    chk("rstwait:late_rvalid2", 32'(lsu_rvalid), 32'd0);

    do_txn("post_rst", 1'b0, 2'b00, 1'b1, 32'h0000_0C02, 32'h0, 0, 32'h00C3_0000, 1'b0, 32'h0000_00C3);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the data-RAM byte-address width.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, as listed below.
REQ-003 The ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- lsu_req  in  1  core requests a load/store.
- lsu_ready  out  1  block can accept a request.
- lsu_we  in  1  1=store, 0=load.
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- lsu_unsigned  in  1  zero-extend load data.
- lsu_addr  in  ADDR_WIDTH  byte address.
- lsu_wdata  in  32  store data, LSB-aligned.
- lsu_rvalid  out  1  one-cycle response strobe.
- lsu_rdata  out  32  extended load data.
- lsu_err  out  1  misalign/bus error flag, valid with lsu_rvalid.
- ram_req  out  1  data-RAM request.
- ram_gnt  in  1  RAM accepted the request.
- ram_rvalid  in  1  RAM response valid.
- ram_we  out  1  RAM write enable.
- ram_be  out  4  RAM byte enables.
- ram_addr  out  ADDR_WIDTH  word-aligned RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.
- ram_err  in  1  RAM error, valid with ram_rvalid.

Function
REQ-004 The block SHALL implement the FSM IDLE -> REQ -> WAIT -> IDLE, with one outstanding transaction at most.
REQ-005 lsu_ready SHALL be 1 only in IDLE; the block SHALL accept a request on a cycle with lsu_req=1 and lsu_ready=1, and SHALL register addr, size, we, unsigned and wdata at that cycle.
REQ-006 On an accepted misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size=11), the block SHALL issue no RAM access, SHALL stay in IDLE-equivalent error response, and SHALL assert lsu_rvalid=1, lsu_err=1 and lsu_rdata=0 on the next cycle.
REQ-007 On an accepted aligned request, the block SHALL enter REQ the next cycle and assert ram_req there, holding ram_req, ram_we, ram_be, ram_addr and ram_wdata stable until a cycle with ram_gnt=1.
REQ-008 On a REQ cycle with ram_gnt=1, the block SHALL drop ram_req on the following cycle and enter WAIT.
REQ-009 ram_rvalid SHALL be sampled only in WAIT and ignored in IDLE and REQ.
REQ-010 On ram_rvalid=1 in WAIT, the block SHALL assert lsu_rvalid for exactly one cycle on the next cycle, with lsu_err=ram_err, and SHALL return to IDLE.
REQ-011 Stores SHALL also wait for ram_rvalid; store responses SHALL return lsu_rdata=0.
REQ-012 ram_addr SHALL be {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-013 ram_be SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, and 1111 for word.
REQ-014 ram_wdata SHALL replicate the data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-015 Load data SHALL be ram_rdata >> (8*addr[1:0]), truncated to size, then zero-extended if lsu_unsigned=1 and sign-extended otherwise.
REQ-016 On a load with ram_err=1, lsu_rdata SHALL be 0.
REQ-017 Minimum aligned latency from acceptance to lsu_rvalid SHALL be 3 cycles, given gnt in the first REQ cycle and rvalid in the first WAIT cycle.

Reset
REQ-018 With reset=0 at a clock edge, the block SHALL enter IDLE, and lsu_rvalid, lsu_err, ram_req and ram_we SHALL be 0, ram_be SHALL be 0000, and lsu_rdata, ram_addr and ram_wdata SHALL be 0.
REQ-019 After reset applied mid-transaction, the block SHALL discard the pending access, and a late ram_rvalid SHALL produce no lsu_rvalid.
REQ-020 lsu_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-021 Package lsu_pkg SHALL hold the lsu_size enum (BYTE, HALF, WORD) and the FSM state enum.
REQ-022 Sub-module lsu_align, purely combinational, SHALL compute be, wdata replication, rdata extraction/extension and the misalign flag.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Store byte addr=0x103, wdata=0xA5, gnt immediate -> ram_addr=0x100, be=1000, ram_wdata=0xA5A5A5A5; lsu_rvalid 3 cycles after acceptance.
- Load half signed addr=0x202, rdata=0x8001_1234 -> lsu_rdata=0xFFFF8001; unsigned -> 0x00008001.
- Load word addr=0x301 -> no ram_req; next cycle lsu_rvalid=1, lsu_err=1, lsu_rdata=0.
- gnt withheld 4 cycles -> ram_req and ram_addr stable for 5 cycles; lsu_ready=0 throughout.
- Load with ram_err=1 -> lsu_err=1, lsu_rdata=0; stray ram_rvalid in IDLE -> no lsu_rvalid.
- reset=0 while in WAIT, then rvalid -> no lsu_rvalid; lsu_ready=1 the cycle after release.
